// File: rtl/fuzz_top_pkg.sv
// fuzz_top_pkg: shared widths, y-field offsets and the packed result layout
// for the fuzz_top arithmetic datapath.
package fuzz_top_pkg;

   localparam int unsigned W0    = 19;
   localparam int unsigned W1    = 17;
   localparam int unsigned W2    = 9;
   localparam int unsigned W3    = 20;
   localparam int unsigned W4    = 21;
   localparam int unsigned WPROD = 26;
   localparam int unsigned WSUM  = 23;
   localparam int unsigned WACC  = 32;
   localparam int unsigned WY    = 81;

   localparam int unsigned ACC_LSB  = 49;
   localparam int unsigned PROD_LSB = 23;
   localparam int unsigned SUM_LSB  = 0;

   // Result word: acc in the top bits, then product, then sum.
   typedef struct packed {
      logic [WACC-1:0]  acc;
      logic [WPROD-1:0] prod;
      logic [WSUM-1:0]  sum;
   } y_t;

   // Sign-extend a product to accumulator width.
   function automatic logic [WACC-1:0] sext_prod(input logic [WPROD-1:0] p);
      return {{(WACC-WPROD){p[WPROD-1]}}, p};
   endfunction

endpackage

// File: rtl/fuzz_top_mac.sv
// fuzz_top_mac: registered signed multiply plus wrapping add/sub accumulator.
// Ports:
//   clk, rst_n : clock, async active-low clear of prod and acc
//   a          : signed multiplicand (W1)
//   b          : signed multiplier (W2)
//   sub        : 1 = subtract product from acc, 0 = add
//   prod       : registered full-precision signed product (WPROD)
//   acc        : registered accumulator, wraps modulo 2^WACC (WACC)
module fuzz_top_mac
   import fuzz_top_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [W1-1:0]    a,
   input  logic [W2-1:0]    b,
   input  logic             sub,
   output logic [WPROD-1:0] prod,
   output logic [WACC-1:0]  acc
);

   logic [WPROD-1:0] a_x;
   logic [WPROD-1:0] b_x;
   logic [WPROD-1:0] prod_n;
   logic [WACC-1:0]  step;
   logic [WACC-1:0]  acc_n;

   // Sign-extended operands make the truncated unsigned product equal to
   // the exact signed product; 17x9 signed bits always fit in 26.
   assign a_x    = {{(WPROD-W1){a[W1-1]}}, a};
   assign b_x    = {{(WPROD-W2){b[W2-1]}}, b};
   assign prod_n = a_x * b_x;

   // Accumulate from the same-cycle product so acc and prod stay aligned.
   assign step  = sext_prod(prod_n);
   assign acc_n = sub ? (acc - step) : (acc + step);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod <= '0;
         acc  <= '0;
      end else begin
         prod <= prod_n;
         acc  <= acc_n;
      end
   end

endmodule

// File: rtl/fuzz_top.sv
// fuzz_top: two-stage registered arithmetic datapath.
// Stage 1 registers the five operand buses; stage 2 produces a signed
// product, a mixed-sign three-operand sum and a wrapping accumulator.
// Ports:
//   clk, rst_n : clock, async active-low reset (clears every register)
//   wire0      : unsigned A0 (19); bit 0 selects subtract in the accumulator
//   wire1      : signed multiplicand (17)
//   wire2      : signed multiplier (9)
//   wire3      : unsigned addend (20)
//   wire4      : signed addend (21)
//   y          : {acc[31:0], prod_q[25:0], sum_q[22:0]} (81)
module fuzz_top
   import fuzz_top_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic [W0-1:0] wire0,
   input  logic [W1-1:0] wire1,
   input  logic [W2-1:0] wire2,
   input  logic [W3-1:0] wire3,
   input  logic [W4-1:0] wire4,
   output logic [WY-1:0] y
);

   logic [W0-1:0]    r0;
   logic [W1-1:0]    r1;
   logic [W2-1:0]    r2;
   logic [W3-1:0]    r3;
   logic [W4-1:0]    r4;
   logic [WSUM-1:0]  sum_q;
   logic [WSUM-1:0]  sum_n;
   logic [WPROD-1:0] prod_q;
   logic [WACC-1:0]  acc;
   y_t               y_w;

   // Stage 1: capture operands unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r0 <= '0;
         r1 <= '0;
         r2 <= '0;
         r3 <= '0;
         r4 <= '0;
      end else begin
         r0 <= wire0;
         r1 <= wire1;
         r2 <= wire2;
         r3 <= wire3;
         r4 <= wire4;
      end
   end

   // Stage 2 sum: signed r4 plus zero-extended r3 and r0; range fits 23 bits.
   assign sum_n = {{(WSUM-W4){r4[W4-1]}}, r4} + WSUM'(r3) + WSUM'(r0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q <= '0;
      end else begin
         sum_q <= sum_n;
      end
   end

   // Stage 2 product and accumulator.
   fuzz_top_mac u_mac (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (r1),
      .b     (r2),
      .sub   (r0[0]),
      .prod  (prod_q),
      .acc   (acc)
   );

   // Output is a pure concatenation of stage-2 registers.
   assign y_w.acc  = acc;
   assign y_w.prod = prod_q;
   assign y_w.sum  = sum_q;
   assign y        = y_w;

endmodule

// File: tb/tb_fuzz_top.sv
// tb_fuzz_top: scoreboard bench for fuzz_top. Stimulus pushes expected y
// words tagged with the clock edge after which they must appear; a monitor
// compares on every falling edge.
module tb_fuzz_top;

   logic        clk;
   logic        rst_n;
   logic [18:0] wire0;
   logic [16:0] wire1;
   logic [8:0]  wire2;
   logic [19:0] wire3;
   logic [20:0] wire4;
   logic [80:0] y;

   typedef struct {
      int          due;
      logic [80:0] exp;
      string       name;
   } exp_t;

   exp_t        sb[$];
   int          edge_cnt = 0;
   int          total    = 0;
   int          bad      = 0;
   logic [31:0] acc_m;

   fuzz_top dut (
      .clk   (clk),
      .rst_n (rst_n),
      .wire0 (wire0),
      .wire1 (wire1),
      .wire2 (wire2),
      .wire3 (wire3),
      .wire4 (wire4),
      .y     (y)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic check(input string name, input logic [80:0] act, input logic [80:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got acc=%h prod=%h sum=%h, expected acc=%h prod=%h sum=%h",
                  name, act[80:49], act[48:23], act[22:0], exp[80:49], exp[48:23], exp[22:0]);
      end
   endtask

   // Monitor: y is stable at the falling edge.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].due <= edge_cnt) begin
         if (sb[0].due == edge_cnt) begin
            check(sb[0].name, y, sb[0].exp);
         end else begin
            total++;
            bad++;
            $display("FAIL %s: missed check slot, due edge %0d now %0d", sb[0].name, sb[0].due, edge_cnt);
         end
         void'(sb.pop_front());
      end
   end

   task automatic push(input int lat, input logic [80:0] exp, input string name);
      exp_t e;
      e.due  = edge_cnt + lat;
      e.exp  = exp;
      e.name = name;
      sb.push_back(e);
   endtask

   task automatic drive(input logic [18:0] a0, input logic [16:0] a1, input logic [8:0] a2,
                        input logic [19:0] a3, input logic [20:0] a4);
      wire0 = a0;
      wire1 = a1;
      wire2 = a2;
      wire3 = a3;
      wire4 = a4;
   endtask

   // Asynchronous reset pulse between edges; in-flight expectations are void.
   task automatic reset_pulse(input string name);
      #2 rst_n = 1'b0;
      #1 check(name, y, 81'd0);
      sb.delete();
      acc_m = 32'd0;
      #1 rst_n = 1'b1;
   endtask

   // Independent reference: integer arithmetic on the raw operands.
   function automatic logic [80:0] model(input logic [18:0] a0, input logic [16:0] a1,
                                         input logic [8:0] a2, input logic [19:0] a3,
                                         input logic [20:0] a4);
      int p;
      int s;
      int x4;
      p  = $signed(a1) * $signed(a2);
      x4 = $signed(a4);
      s  = x4 + int'(a3) + int'(a0);
      if (a0[0]) acc_m = acc_m - 32'(p);
      else       acc_m = acc_m + 32'(p);
      return {acc_m, p[25:0], s[22:0]};
   endfunction

   initial begin
      logic [18:0] ra0;
      logic [16:0] ra1;
      logic [8:0]  ra2;
      logic [19:0] ra3;
      logic [20:0] ra4;
      logic [80:0] e;
      int          guard;

      rst_n = 1'b1;
      drive(19'd0, 17'd0, 9'd0, 20'd0, 21'd0);
      acc_m = 32'd0;
      #1 rst_n = 1'b0;

      // Reset held: clocks and arbitrary inputs must not disturb y.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("reset_hold", y, 81'd0);
         drive(19'h5A5A5, 17'h1ABCD, 9'h1F3, 20'hF00F0, 21'h155555);
      end

      // Release with the basic-add vector present at the first edge.
      @(negedge clk);
      rst_n = 1'b1;
      drive(19'd2, 17'd3, 9'h1FE, 20'd5, 21'h1FFFFF);
      push(1, 81'd0, "post_release_first_edge");
      push(2, {32'hFFFFFFFA, 26'h3FFFFFA, 23'd6}, "basic_add");
      @(negedge clk);
      drive(19'd0, 17'd0, 9'd0, 20'd0, 21'd0);
      @(negedge clk);
      @(negedge clk);

      // Subtract mode from a cleared accumulator.
      reset_pulse("async_clear_1");
      drive(19'd1, 17'h1FFFC, 9'd5, 20'd0, 21'd0);
      push(1, 81'd0, "sub_first_edge");
      push(2, {32'd20, 26'h3FFFFEC, 23'd1}, "sub_mode");
      @(negedge clk);
      drive(19'd0, 17'd0, 9'd0, 20'd0, 21'd0);
      @(negedge clk);

      // Extreme operands; acc continues from 20.
      drive(19'h7FFFE, 17'h10000, 9'h100, 20'hFFFFF, 21'h0FFFFF);
      push(2, {32'h01000014, 26'h1000000, 23'h27FFFC}, "extremes");
      @(negedge clk);
      drive(19'd0, 17'd0, 9'd0, 20'd0, 21'd0);
      @(negedge clk);
      @(negedge clk);

      // Wrap: preset acc to FFFFFFFE then add 1 three times.
      reset_pulse("async_clear_2");
      drive(19'd0, 17'h1FFFE, 9'd1, 20'd0, 21'd0);
      push(2, {32'hFFFFFFFE, 26'h3FFFFFE, 23'd0}, "wrap_preset");
      @(negedge clk);
      drive(19'd0, 17'd1, 9'd1, 20'd0, 21'd0);
      push(2, {32'hFFFFFFFF, 26'd1, 23'd0}, "wrap_ffffffff");
      @(negedge clk);
      push(2, {32'h00000000, 26'd1, 23'd0}, "wrap_zero");
      @(negedge clk);
      push(2, {32'h00000001, 26'd1, 23'd0}, "wrap_one");
      @(negedge clk);
      drive(19'd0, 17'd0, 9'd0, 20'd0, 21'd0);
      @(negedge clk);
      @(negedge clk);

      // Random stream with a mid-stream reset pulse; model restarts from zero.
      reset_pulse("async_clear_3");
      for (int i = 0; i < 20; i++) begin
         if (i == 10) reset_pulse("async_clear_midstream");
         ra0 = 19'($urandom);
         ra1 = 17'($urandom);
         ra2 = 9'($urandom);
         ra3 = 20'($urandom);
         ra4 = 21'($urandom);
         drive(ra0, ra1, ra2, ra3, ra4);
         e = model(ra0, ra1, ra2, ra3, ra4);
         push(2, e, "random_stream");
         @(negedge clk);
      end
      drive(19'd0, 17'd0, 9'd0, 20'd0, 21'd0);

      // Drain with a bounded wait.
      guard = 0;
      while (sb.size() > 0 && guard < 10) begin
         @(negedge clk);
         guard++;
      end
      if (sb.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain: %0d expectations left, required 0", sb.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

endmodule
